// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: round-robin, packet-granular arbiter sharing one FIFO write port
module sync_fifo_wr_arbiter #(
   parameter  int C_NUM_CHNL  = 4,
   parameter  int C_WIDTH     = 32,
   parameter  int C_MAX_WORDS = 256,
   localparam int C_CHNL_BITS = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1,
   localparam int C_CNT_BITS  = $clog2(C_MAX_WORDS + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic [C_NUM_CHNL-1:0]           chnl_valid_i,
   input  logic [C_NUM_CHNL*C_WIDTH-1:0]   chnl_data_i,
   input  logic [C_NUM_CHNL-1:0]           chnl_last_i,
   output logic [C_NUM_CHNL-1:0]           chnl_ready_o,
   output logic [C_WIDTH+C_CHNL_BITS:0]    fifo_wr_data_o,
   output logic                            fifo_wr_en_o,
   input  logic                            fifo_full_i,
   output logic [C_NUM_CHNL-1:0]           gnt_o,
   output logic                            busy_o,
   output logic [C_CNT_BITS-1:0]           burst_cnt_o
);

   typedef enum logic {S_IDLE, S_XFER} state_t;

   state_t                 state_q, state_d;
   logic [C_CHNL_BITS-1:0] gnt_idx_q, gnt_idx_d;
   logic [C_CHNL_BITS-1:0] last_gnt_q, last_gnt_d;
   logic [C_CNT_BITS-1:0]  burst_cnt_q, burst_cnt_d;
   logic [C_CHNL_BITS-1:0] rr_idx, sel_idx;
   logic                   sel_vld;
   logic                   g_valid, g_last, xfer, done;
   logic [C_WIDTH-1:0]     g_data;

   // state register; reset leaves last grant on the top channel so channel 0 wins first
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         gnt_idx_q   <= '0;
         last_gnt_q  <= C_CHNL_BITS'(C_NUM_CHNL - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_idx_q   <= gnt_idx_d;
         last_gnt_q  <= last_gnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // round-robin search: first requester after the last grant, lowest distance wins
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      rr_idx  = '0;
      for (int k = C_NUM_CHNL; k >= 1; k--) begin
         rr_idx = (int'(last_gnt_q) + k >= C_NUM_CHNL) ? C_CHNL_BITS'(int'(last_gnt_q) + k - C_NUM_CHNL)
                                                       : C_CHNL_BITS'(int'(last_gnt_q) + k);
         if (chnl_valid_i[rr_idx]) begin
            sel_vld = 1'b1;
            sel_idx = rr_idx;
         end
      end
   end

   // granted-channel mux plus accept and grant-exit conditions
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int i = 0; i < C_NUM_CHNL; i++) begin
         if (gnt_idx_q == C_CHNL_BITS'(i)) begin
            g_valid = chnl_valid_i[i];
            g_last  = chnl_last_i[i];
            g_data  = chnl_data_i[i*C_WIDTH +: C_WIDTH];
         end
      end
      xfer = (state_q == S_XFER) && g_valid && !fifo_full_i;
      done = xfer && (g_last || burst_cnt_q == C_CNT_BITS'(C_MAX_WORDS - 1));
   end

   // next state: IDLE always lasts one cycle, so consecutive grants get a bubble
   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      last_gnt_d  = last_gnt_q;
      burst_cnt_d = burst_cnt_q;
      if (state_q == S_IDLE) begin
         state_d   = sel_vld ? S_XFER : S_IDLE;
         gnt_idx_d = sel_vld ? sel_idx : gnt_idx_q;
      end else if (xfer) begin
         state_d     = done ? S_IDLE : S_XFER;
         last_gnt_d  = done ? gnt_idx_q : last_gnt_q;
         burst_cnt_d = done ? '0 : burst_cnt_q + C_CNT_BITS'(1);
      end
   end

   // outputs: write strobe and READY follow the accept condition combinationally
   always_comb begin
      busy_o         = (state_q == S_XFER);
      fifo_wr_en_o   = xfer;
      fifo_wr_data_o = {g_last, gnt_idx_q, g_data};
      burst_cnt_o    = burst_cnt_q;
      for (int i = 0; i < C_NUM_CHNL; i++) begin
         gnt_o[i]        = busy_o && (gnt_idx_q == C_CHNL_BITS'(i));
         chnl_ready_o[i] = xfer && (gnt_idx_q == C_CHNL_BITS'(i));
      end
   end

   // the FIFO is never written while it reports full
   a_no_wr_full : assert property (@(posedge clk_i) disable iff (!rst_n_i) !(fifo_wr_en_o && fifo_full_i));

   // at most one channel holds the grant
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(gnt_o));

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb_sync_fifo_wr_arbiter: scoreboard bench for the round-robin FIFO write arbiter
module tb_sync_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int MW = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   chnl_valid = '0;
   logic [N-1:0]   chnl_last = '0;
   logic [N*W-1:0] chnl_data = '0;
   logic           fifo_full = 1'b0;
   logic [N-1:0]   chnl_ready, gnt;
   logic [W+2:0]   wr_data;
   logic           wr_en, busy;
   logic [2:0]     burst_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_seen = 0;
   logic [W+2:0] exp_q[$];
   int wr_cyc[$];
   logic [W:0] src_mem [N][64];
   int src_hd [N] = '{default: 0};
   int src_tl [N] = '{default: 0};
   logic [N-1:0] gap = '0;
   logic [N-1:0] acc = '0;

   sync_fifo_wr_arbiter #(.C_NUM_CHNL(N), .C_WIDTH(W), .C_MAX_WORDS(MW)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .chnl_valid_i(chnl_valid), .chnl_data_i(chnl_data), .chnl_last_i(chnl_last),
      .chnl_ready_o(chnl_ready), .fifo_wr_data_o(wr_data), .fifo_wr_en_o(wr_en),
      .fifo_full_i(fifo_full), .gnt_o(gnt), .busy_o(busy), .burst_cnt_o(burst_cnt)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [W-1:0] word(input int ch, input int tag, input int k);
      return W'(32'hA000_0000 + (ch << 16) + (tag << 8) + k);
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (src_hd[i] < src_tl[i] && !gap[i]) begin
            chnl_valid[i]       = 1'b1;
            chnl_last[i]        = src_mem[i][src_hd[i]][W];
            chnl_data[i*W +: W] = src_mem[i][src_hd[i]][W-1:0];
         end else begin
            chnl_valid[i] = 1'b0;
            chnl_last[i]  = 1'b0;
         end
      end
   endtask

   task automatic push_pkt(input int ch, input int tag, input int n);
      for (int k = 0; k < n; k++) begin
         src_mem[ch][src_tl[ch]] = {k == n - 1, word(ch, tag, k)};
         src_tl[ch]++;
      end
      drive();
   endtask

   task automatic expw(input int ch, input int tag, input int k, input logic last);
      exp_q.push_back({last, 2'(ch), word(ch, tag, k)});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_writes(input int n);
      int t = 0;
      while (wr_seen < n && t < 100) begin
         tick();
         t++;
      end
      check("wait_writes", 64'(wr_seen), 64'(n));
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 200) begin
         tick();
         t++;
      end
      check({name, "_drain"}, 64'(exp_q.size()), 0);
      check({name, "_idle"}, busy, 0);
   endtask

   initial forever #5 clk = ~clk;

   // channel sources: pop a word once the DUT accepted it at the previous edge
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) src_hd[i]++;
      drive();
   end

   // monitor: scoreboard compare on every FIFO write
   initial forever begin
      @(negedge clk);
      acc = chnl_ready & chnl_valid;
      check("ready_vs_gnt", chnl_ready, wr_en ? gnt : '0);
      if (fifo_full) check("no_wr_when_full", wr_en, 0);
      if (wr_en) begin
         wr_cyc.push_back(cyc);
         wr_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got %0h with empty scoreboard", wr_data);
         end else check("fifo_word", wr_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal;
   end

   initial begin
      drive();
      tick();
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_burst", burst_cnt, 0);
      check("rst_ready", chnl_ready, 0);
      check("rst_wr_en", wr_en, 0);
      rst_n = 1'b1;
      tick();

      // fairness: grants 0,1,2,3,0 with one bubble each
      wr_cyc.delete();
      push_pkt(0, 1, 2);
      push_pkt(1, 1, 2);
      push_pkt(2, 1, 2);
      push_pkt(3, 1, 2);
      push_pkt(0, 2, 2);
      for (int c = 0; c < 4; c++) begin
         expw(c, 1, 0, 1'b0);
         expw(c, 1, 1, 1'b1);
      end
      expw(0, 2, 0, 1'b0);
      expw(0, 2, 1, 1'b1);
      wait_drain("fair");
      check("fair_words", 64'(wr_cyc.size()), 10);
      if (wr_cyc.size() >= 8) begin
         check("fair_11_cycles", 64'(wr_cyc[7] - wr_cyc[0]), 10);
         check("fair_bubble", 64'(wr_cyc[2] - wr_cyc[1]), 2);
      end

      // single packet on ch2: one arbitration cycle, consecutive writes
      wr_cyc.delete();
      push_pkt(2, 3, 3);
      expw(2, 3, 0, 1'b0);
      expw(2, 3, 1, 1'b0);
      expw(2, 3, 2, 1'b1);
      #1;
      check("one_arb_cycle", gnt, 0);
      tick();
      check("one_gnt", gnt, 4'b0100);
      check("one_busy", busy, 1);
      wait_drain("one");
      if (wr_cyc.size() == 3) check("one_consecutive", 64'(wr_cyc[2] - wr_cyc[0]), 2);

      // last grant was 2, so ch3 beats ch1
      push_pkt(1, 4, 1);
      push_pkt(3, 4, 1);
      expw(3, 4, 0, 1'b1);
      expw(1, 4, 0, 1'b1);
      tick();
      check("rr_after_2", gnt, 4'b1000);
      wait_drain("rr");

      // backpressure on ch1 for 5 cycles after 2 words; 4th word hits cap and LAST together
      wr_seen = 0;
      push_pkt(1, 5, 4);
      for (int k = 0; k < 4; k++) expw(1, 5, k, k == 3);
      wait_writes(2);
      fifo_full = 1'b1;
      #1;
      check("bp_burst_cnt", burst_cnt, 2);
      for (int i = 0; i < 5; i++) begin
         check("bp_wr_en", wr_en, 0);
         check("bp_ready", chnl_ready, 0);
         check("bp_gnt", gnt, 4'b0010);
         tick();
         #1;
      end
      fifo_full = 1'b0;
      #1;
      check("bp_resume_wr", wr_en, 1);
      check("bp_resume_ready", chnl_ready, 4'b0010);
      wait_drain("bp");

      // burst cap: ch0 6 words split 4+2 around ch1's single word
      wr_cyc.delete();
      push_pkt(0, 6, 6);
      push_pkt(1, 6, 1);
      for (int k = 0; k < 4; k++) expw(0, 6, k, 1'b0);
      expw(1, 6, 0, 1'b1);
      expw(0, 6, 4, 1'b0);
      expw(0, 6, 5, 1'b1);
      wait_drain("cap");
      if (wr_cyc.size() == 7) begin
         check("cap_bubble_a", 64'(wr_cyc[4] - wr_cyc[3]), 2);
         check("cap_bubble_b", 64'(wr_cyc[5] - wr_cyc[4]), 2);
      end

      // VALID gap on ch3 while ch0 waits
      wr_seen = 0;
      push_pkt(3, 7, 3);
      push_pkt(0, 7, 1);
      for (int k = 0; k < 3; k++) expw(3, 7, k, k == 2);
      expw(0, 7, 0, 1'b1);
      wait_writes(1);
      gap[3] = 1'b1;
      drive();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("gap_gnt", gnt, 4'b1000);
         check("gap_busy", busy, 1);
         check("gap_wr_en", wr_en, 0);
         tick();
      end
      gap[3] = 1'b0;
      drive();
      wait_drain("gap");

      // async reset after 2 of 5 words on ch2; ch0 then ch1 then ch2's remainder
      wr_seen = 0;
      push_pkt(2, 8, 5);
      expw(2, 8, 0, 1'b0);
      expw(2, 8, 1, 1'b0);
      expw(0, 8, 0, 1'b1);
      expw(1, 8, 0, 1'b1);
      expw(2, 8, 2, 1'b0);
      expw(2, 8, 3, 1'b0);
      expw(2, 8, 4, 1'b1);
      wait_writes(2);
      push_pkt(0, 8, 1);
      push_pkt(1, 8, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_gnt", gnt, 0);
      check("arst_ready", chnl_ready, 0);
      check("arst_wr_en", wr_en, 0);
      check("arst_busy", busy, 0);
      check("arst_burst", burst_cnt, 0);
      rst_n = 1'b1;
      tick();
      check("arst_ch0_first", gnt, 4'b0001);
      wait_drain("arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one sync_fifo write port among C_NUM_CHNL requester channels.
- Grants are packet-granular: a grant is held until LAST is accepted, or until C_MAX_WORDS words have been written.
- Every FIFO entry is tagged with its channel ID and a last flag, so the downstream reader can demultiplex interleaved bursts.
- Sits between per-channel TX engines and the shared sync_fifo instance.

Parameters:
- C_NUM_CHNL, 4, number of requester channels (2..12).
- C_WIDTH, 32, payload data width.
- C_MAX_WORDS, 256, burst cap: maximum words written per grant.
- C_CHNL_BITS, clog2s(C_NUM_CHNL), local; channel tag width.
- C_CNT_BITS, clog2s(C_MAX_WORDS+1), local; burst counter width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous reset, active-low.
- CHNL_VALID  in  C_NUM_CHNL  per-channel word valid.
- CHNL_DATA  in  C_NUM_CHNL*C_WIDTH  per-channel data; channel i occupies bits [i*C_WIDTH +: C_WIDTH].
- CHNL_LAST  in  C_NUM_CHNL  per-channel last-word-of-packet flag.
- CHNL_READY  out  C_NUM_CHNL  per-channel word accepted this cycle.
- FIFO_WR_DATA  out  C_WIDTH+C_CHNL_BITS+1  {last, chnl_id, data}.
- FIFO_WR_EN  out  1  write strobe to the FIFO.
- FIFO_FULL  in  1  registered FULL from the FIFO.
- GNT  out  C_NUM_CHNL  one-hot current grant; 0 when IDLE.
- BUSY  out  1  high in XFER.
- BURST_CNT  out  C_CNT_BITS  words written in the current grant.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, GNT=0, BUSY=0, BURST_CNT=0.
  - rLastGnt=C_NUM_CHNL-1, so channel 0 has first priority.
  - CHNL_READY=0, FIFO_WR_EN=0.
- Reset mid-XFER aborts immediately. No partial-word write; words already written stay in the FIFO.
- Two-state FSM:
  - IDLE: if any CHNL_VALID, select the first asserted channel searching from rLastGnt+1 upward, wrapping modulo C_NUM_CHNL. Register GNT and go to XFER next cycle. Arbitration costs exactly one cycle. No request means stay in IDLE.
  - XFER: g = granted index.
    - Accept condition: xfer = CHNL_VALID[g] & !FIFO_FULL.
    - CHNL_READY[g] = xfer, combinational. All other READY bits are 0.
    - FIFO_WR_EN = xfer, combinational. FIFO_WR_DATA = {CHNL_LAST[g], g, CHNL_DATA[g]}.
    - BURST_CNT increments on each xfer.
    - Exit to IDLE on xfer when CHNL_LAST[g]=1 or BURST_CNT+1==C_MAX_WORDS. On exit: rLastGnt=g, BURST_CNT=0, GNT=0.
    - VALID gaps mid-packet: stay in XFER holding the grant; no timeout.
- Mandatory bubble: one IDLE cycle between consecutive grants, including back-to-back grants to the same channel.
- FIFO_WR_EN never asserts while FIFO_FULL=1. FIFO_FULL is registered and includes WR_EN look-ahead, so a write on the cycle FULL is low is always safe.
- Burst cap split: the packet's remaining words resume on that channel's next grant. The tag identifies the channel and last=0 on the capped word. Round-robin rotates, so other channels are serviced between the two parts.
- Simultaneous LAST and cap on the same word: single exit, last=1.
- Single active channel: re-granted after each bubble, giving 1 idle cycle per grant.
- Data path is combinational from the selected channel; the output mux is indexed by registered g.

Test Plan:
- Single packet: ch2 sends 3 words D0..D2 (LAST on D2), FIFO empty.
  - GNT=4'b0100 one cycle after VALID.
  - FIFO receives {0,2,D0},{0,2,D1},{1,2,D2} on consecutive cycles.
  - Then IDLE, and rLastGnt=2.
- Fairness: all 4 channels hold VALID with 2-word packets.
  - Grant order is 0,1,2,3,0.
  - Each grant is separated by exactly 1 IDLE cycle.
  - 8 words are written in 11 cycles from first GNT.
- Backpressure: FIFO_FULL forced high for 5 cycles mid-packet on ch1.
  - FIFO_WR_EN=0 and CHNL_READY=0 during those cycles; GNT stays 4'b0010.
  - Transfer resumes on the first cycle FULL is low; no word is lost or duplicated.
- Burst cap: C_MAX_WORDS=4; ch0 sends a 6-word packet while ch1 has a 1-word packet.
  - Sequence: ch0 words 1-4 (last=0), IDLE, ch1 word (last=1), IDLE, ch0 words 5-6 (last=1 on word 6).
- VALID gap: ch3 drops VALID for 3 cycles mid-packet while ch0 is requesting.
  - GNT stays 4'b1000 and BUSY=1 throughout.
  - ch0 is granted only after ch3's LAST.
- Async reset mid-XFER: RST_N pulses low between clock edges after 2 of 5 words.
  - GNT, CHNL_READY, and FIFO_WR_EN go to 0 immediately.
  - After release, channel 0 has highest priority.
